// File: rtl/blk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : blk_pkg
//  Purpose  : Shared definitions for the block scheduler: FSM state
//             encoding, default geometry and small width/size helpers.
//  Revision : 1.0  initial release
// ============================================================================
package blk_pkg;

    // Scheduler states, explicitly encoded on two bits.
    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,   // idle after reset, waiting for a frame start
        ST_LINE   = 2'd1,   // active video of a line is being counted
        ST_HBLANK = 2'd2,   // between lines of a running frame
        ST_DONE   = 2'd3    // all block rows of the frame have been seen
    } blk_state_t;

    // Default geometry used by the top-level parameters.
    localparam int DEF_HBLKS  = 10;
    localparam int DEF_VBLKS  = 10;
    localparam int DEF_HBLK_W = 30;
    localparam int DEF_VBLK_H = 30;

    // Nominal pixels per line for the default geometry.
    localparam int LINE_PX = DEF_HBLKS * DEF_HBLK_W;

    // Pixels per line for an arbitrary geometry.
    function automatic int calc_line_px(input int hblks, input int hblk_w);
        return hblks * hblk_w;
    endfunction

    // Minimum width able to hold 0..n-1, never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/blk_sched_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : edge_det
//  Purpose  : Registered rise/fall detector. The previous sample is held in
//             a flop; edges are flagged in the same cycle the new level
//             appears on the input.
//  Ports    : clk     - clock
//             rst     - synchronous active-high reset (history cleared to 0)
//             i_d     - level input
//             o_rise  - high for the cycle where i_d goes 0 -> 1
//             o_fall  - high for the cycle where i_d goes 1 -> 0
//  Revision : 1.0  initial release
// ============================================================================
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise =  i_d & ~r_q;
    assign o_fall = ~i_d &  r_q;

endmodule
`default_nettype wire

// File: rtl/blk_sched.sv
`default_nettype none
// ============================================================================
//  Module   : blk_sched
//  Purpose  : Block scheduler for a video stream. Splits each frame into a
//             grid of HBLKS x VBLKS blocks of HBLK_W pixels by VBLK_H lines,
//             delays the pixel stream by one cycle and emits save strobes
//             aligned with it.
//  Ports    : clk_i     - clock (rising edge)
//             rst_i     - synchronous active-high reset
//             de_i      - active-video enable
//             vs_i      - vertical sync, rising edge starts a frame
//             wd_i      - RGB 8:8:8 pixel data
//             de_o/wd_o - de_i/wd_i delayed by one cycle
//             h_save_o  - pulse on the last pixel of each horizontal block
//             v_save_o  - pulse at frame start and at each block-row boundary
//             bx_o      - horizontal block index of the pixel on wd_o
//             by_o      - current block row
//             err_o     - sticky line-length error, cleared at frame start
//  Revision : 1.0  initial release
// ============================================================================
module blk_sched
    import blk_pkg::*;
#(
    parameter int HBLKS  = DEF_HBLKS,
    parameter int VBLKS  = DEF_VBLKS,
    parameter int HBLK_W = DEF_HBLK_W,
    parameter int VBLK_H = DEF_VBLK_H
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     de_i,
    input  logic                     vs_i,
    input  logic [23:0]              wd_i,
    output logic                     de_o,
    output logic [23:0]              wd_o,
    output logic                     h_save_o,
    output logic                     v_save_o,
    output logic [$clog2(HBLKS)-1:0] bx_o,
    output logic [$clog2(VBLKS)-1:0] by_o,
    output logic                     err_o
);

    localparam int c_line_px = calc_line_px(HBLKS, HBLK_W);
    localparam int c_px_w    = cnt_width(HBLK_W);
    localparam int c_ln_w    = cnt_width(VBLK_H);
    localparam int c_bx_w    = $clog2(HBLKS);
    localparam int c_by_w    = $clog2(VBLKS);
    // The line counter saturates one past the nominal length so that an
    // over-long line remains distinguishable from a correct one.
    localparam int c_cnt_w   = $clog2(c_line_px + 2);

    // ------------------------------------------------------------------
    // Edge detection on the timing inputs
    // ------------------------------------------------------------------
    logic w_de_rise;
    logic w_de_fall;
    logic w_vs_rise;
    logic w_unused_vs_fall;

    edge_det u_de_edge (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_d    (de_i),
        .o_rise (w_de_rise),
        .o_fall (w_de_fall)
    );

    edge_det u_vs_edge (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_d    (vs_i),
        .o_rise (w_vs_rise),
        .o_fall (w_unused_vs_fall)
    );

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    blk_state_t          r_state, w_state_nxt;
    logic [c_px_w-1:0]   r_px,    w_px_nxt;     // pixel within block
    logic [c_bx_w-1:0]   r_bx,    w_bx_nxt;     // block of next pixel
    logic [c_ln_w-1:0]   r_ln,    w_ln_nxt;     // line within block row
    logic [c_by_w-1:0]   r_by,    w_by_nxt;     // block row
    logic [c_cnt_w-1:0]  r_cnt,   w_cnt_nxt;    // pixels seen on this line
    logic                r_err,   w_err_nxt;
    logic [c_bx_w-1:0]   r_bx_o,  w_bx_o_nxt;   // block of pixel on wd_o
    logic                r_h_save, w_h_save_nxt;
    logic                r_v_save, w_v_save_nxt;
    logic                r_de_o;
    logic [23:0]         r_wd_o;
    logic                w_take_px;

    always_comb begin
        w_state_nxt  = r_state;
        w_px_nxt     = r_px;
        w_bx_nxt     = r_bx;
        w_ln_nxt     = r_ln;
        w_by_nxt     = r_by;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        w_bx_o_nxt   = r_bx_o;
        w_h_save_nxt = 1'b0;
        w_v_save_nxt = 1'b0;
        w_take_px    = 1'b0;

        if (w_vs_rise) begin
            // Frame start wins over everything else, whatever the state.
            w_state_nxt  = ST_HBLANK;
            w_px_nxt     = '0;
            w_bx_nxt     = '0;
            w_ln_nxt     = '0;
            w_by_nxt     = '0;
            w_cnt_nxt    = '0;
            w_err_nxt    = 1'b0;
            w_bx_o_nxt   = '0;
            w_v_save_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_HBLANK: begin
                    // Counters are already zero here: they are cleared at
                    // frame start and at every line end.
                    if (w_de_rise) begin
                        w_state_nxt = ST_LINE;
                        w_take_px   = 1'b1;
                    end
                end
                ST_LINE: begin
                    if (w_de_fall) begin
                        w_state_nxt = ST_HBLANK;
                        w_px_nxt    = '0;
                        w_bx_nxt    = '0;
                        w_cnt_nxt   = '0;
                        if (r_cnt != c_cnt_w'(c_line_px)) begin
                            w_err_nxt = 1'b1;
                        end
                        if (r_ln == c_ln_w'(VBLK_H - 1)) begin
                            w_ln_nxt = '0;
                            if (r_by == c_by_w'(VBLKS - 1)) begin
                                // Last row: the frame-start pulse already
                                // accounted for the first row boundary.
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_by_nxt     = r_by + 1'b1;
                                w_v_save_nxt = 1'b1;
                            end
                        end else begin
                            w_ln_nxt = r_ln + 1'b1;
                        end
                    end else begin
                        w_take_px = 1'b1;
                    end
                end
                default: begin
                    // WAIT and DONE ignore de_i entirely.
                end
            endcase
        end

        if (w_take_px) begin
            if (r_cnt < c_cnt_w'(c_line_px)) begin
                w_bx_o_nxt = r_bx;
                if (r_px == c_px_w'(HBLK_W - 1)) begin
                    w_h_save_nxt = 1'b1;
                    w_px_nxt     = '0;
                    if (r_bx != c_bx_w'(HBLKS - 1)) begin
                        w_bx_nxt = r_bx + 1'b1;
                    end
                end else begin
                    w_px_nxt = r_px + 1'b1;
                end
            end
            if (r_cnt != c_cnt_w'(c_line_px + 1)) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_WAIT;
            r_px     <= '0;
            r_bx     <= '0;
            r_ln     <= '0;
            r_by     <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_bx_o   <= '0;
            r_h_save <= 1'b0;
            r_v_save <= 1'b0;
            r_de_o   <= 1'b0;
            r_wd_o   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_px     <= w_px_nxt;
            r_bx     <= w_bx_nxt;
            r_ln     <= w_ln_nxt;
            r_by     <= w_by_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_bx_o   <= w_bx_o_nxt;
            r_h_save <= w_h_save_nxt;
            r_v_save <= w_v_save_nxt;
            r_de_o   <= de_i;
            r_wd_o   <= wd_i;
        end
    end

    assign de_o     = r_de_o;
    assign wd_o     = r_wd_o;
    assign h_save_o = r_h_save;
    assign v_save_o = r_v_save;
    assign bx_o     = r_bx_o;
    assign by_o     = r_by;
    assign err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_blk_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_blk_sched
//  Purpose  : Self-checking bench for blk_sched with a frame/line level
//             reference model (pixel index within line, lines within frame).
//  Revision : 1.0  initial release
// ============================================================================
module tb_blk_sched;

    localparam int HBLKS   = 4;
    localparam int VBLKS   = 3;
    localparam int HBLK_W  = 8;
    localparam int VBLK_H  = 2;
    localparam int LINE_PX = HBLKS * HBLK_W;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        de_i = 1'b0;
    logic        vs_i = 1'b0;
    logic [23:0] wd_i = '0;
    logic        de_o;
    logic [23:0] wd_o;
    logic        h_save_o;
    logic        v_save_o;
    logic [1:0]  bx_o;
    logic [1:0]  by_o;
    logic        err_o;

    always #5 clk = ~clk;

    blk_sched #(
        .HBLKS  (HBLKS),
        .VBLKS  (VBLKS),
        .HBLK_W (HBLK_W),
        .VBLK_H (VBLK_H)
    ) u_dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .de_i     (de_i),
        .vs_i     (vs_i),
        .wd_i     (wd_i),
        .de_o     (de_o),
        .wd_o     (wd_o),
        .h_save_o (h_save_o),
        .v_save_o (v_save_o),
        .bx_o     (bx_o),
        .by_o     (by_o),
        .err_o    (err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_active, m_in_line, m_prev_de, m_prev_vs, m_err;
    int m_pix, m_lines, m_bx, m_by;

    // Observed pulse tallies for scenario-level checks
    int h_seen, v_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, advance the model, compare after edge.
    task automatic cycle(input logic de, input logic vs, input logic rst);
        logic [23:0] d;
        logic        e_de, e_h, e_v;
        logic [23:0] e_wd;
        d     = 24'($urandom);
        rst_i = rst;
        de_i  = de;
        vs_i  = vs;
        wd_i  = d;

        if (rst) begin
            m_active = 0; m_in_line = 0; m_prev_de = 0; m_prev_vs = 0;
            m_err = 0; m_bx = 0; m_by = 0; m_lines = 0; m_pix = 0;
            e_de = 0; e_wd = '0; e_h = 0; e_v = 0;
        end else begin
            e_de = de; e_wd = d; e_h = 0; e_v = 0;
            if (vs && !m_prev_vs) begin
                m_active = 1; m_in_line = 0; m_lines = 0; m_err = 0;
                m_bx = 0; m_by = 0; e_v = 1;
            end else if (m_active) begin
                if (m_in_line && !de) begin
                    m_in_line = 0;
                    if (m_pix != LINE_PX) m_err = 1;
                    m_lines++;
                    if (m_lines % VBLK_H == 0) begin
                        if (m_lines == VBLK_H * VBLKS) begin
                            m_active = 0;
                        end else begin
                            e_v  = 1;
                            m_by = m_lines / VBLK_H;
                        end
                    end
                end else if (de) begin
                    if (!m_in_line && !m_prev_de) begin
                        m_in_line = 1;
                        m_pix     = 0;
                    end
                    if (m_in_line) begin
                        if (m_pix < LINE_PX) begin
                            m_bx = m_pix / HBLK_W;
                            e_h  = ((m_pix % HBLK_W) == HBLK_W - 1);
                        end
                        m_pix++;
                    end
                end
            end
            m_prev_de = de;
            m_prev_vs = vs;
        end

        @(posedge clk);
        #1;
        chk("de_o",     32'(de_o),     32'(e_de));
        chk("wd_o",     32'(wd_o),     32'(e_wd));
        chk("h_save_o", 32'(h_save_o), 32'(e_h));
        chk("v_save_o", 32'(v_save_o), 32'(e_v));
        chk("bx_o",     32'(bx_o),     32'(m_bx));
        chk("by_o",     32'(by_o),     32'(m_by));
        chk("err_o",    32'(err_o),    32'(m_err));
        if (h_save_o) h_seen++;
        if (v_save_o) v_seen++;
    endtask

    // A line of n pixels followed by gap idle cycles; optional reset or
    // vsync injected at a given pixel index (-1 = none).
    task automatic drive_line(input int n, input int gap, input int rst_at, input int vs_at);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, (i == vs_at), (i == rst_at));
        end
        for (int i = 0; i < gap; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic vs_pulse();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr_tally();
        h_seen = 0;
        v_seen = 0;
    endtask

    initial begin
        int r;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0);

        // de activity before any frame start
        clr_tally();
        drive_line(LINE_PX, 4, -1, -1);
        drive_line(LINE_PX, 4, -1, -1);
        chk("prevs_h", 32'(h_seen), 32'd0);
        chk("prevs_v", 32'(v_seen), 32'd0);
        chk("prevs_bx", 32'(bx_o), 32'd0);
        chk("prevs_by", 32'(by_o), 32'd0);

        // Full frame
        clr_tally();
        vs_pulse();
        for (int l = 0; l < VBLK_H * VBLKS; l++) drive_line(LINE_PX, $urandom_range(2, 6), -1, -1);
        chk("frame_h", 32'(h_seen), 32'd24);
        chk("frame_v", 32'(v_seen), 32'd3);
        chk("frame_err", 32'(err_o), 32'd0);

        // Line after DONE
        clr_tally();
        drive_line(LINE_PX, 4, -1, -1);
        chk("done_h", 32'(h_seen), 32'd0);
        chk("done_v", 32'(v_seen), 32'd0);

        // Short line
        vs_pulse();
        clr_tally();
        drive_line(30, 4, -1, -1);
        chk("short_h", 32'(h_seen), 32'd3);
        chk("short_err", 32'(err_o), 32'd1);
        vs_pulse();
        chk("vs_clr_err", 32'(err_o), 32'd0);

        // Long line
        clr_tally();
        drive_line(40, 4, -1, -1);
        chk("long_h", 32'(h_seen), 32'd4);
        chk("long_err", 32'(err_o), 32'd1);

        // Reset in the middle of line 3
        vs_pulse();
        drive_line(LINE_PX, 3, -1, -1);
        drive_line(LINE_PX, 3, -1, -1);
        drive_line(LINE_PX, 3, 13, -1);
        clr_tally();
        for (int l = 0; l < 3; l++) drive_line(LINE_PX, 3, -1, -1);
        chk("rst_h", 32'(h_seen), 32'd0);
        chk("rst_v", 32'(v_seen), 32'd0);
        clr_tally();
        vs_pulse();
        for (int l = 0; l < VBLK_H * VBLKS; l++) drive_line(LINE_PX, 3, -1, -1);
        chk("resume_h", 32'(h_seen), 32'd24);
        chk("resume_v", 32'(v_seen), 32'd3);

        // Randomized mix of frames, odd lengths, vsync and reset intrusions
        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                vs_pulse();
            end else if (r == 1) begin
                cycle(1'b0, 1'b0, 1'b1);
                cycle(1'b0, 1'b0, 1'b0);
            end else if (r == 2) begin
                drive_line($urandom_range(20, 40), $urandom_range(1, 4), -1, $urandom_range(0, 19));
            end else if (r == 3) begin
                // vsync landing on the cycle after the line end
                drive_line(LINE_PX, 0, -1, -1);
                cycle(1'b0, 1'b1, 1'b0);
                cycle(1'b1, 1'b1, 1'b0);
                cycle(1'b0, 1'b0, 1'b0);
            end else if (r < 9) begin
                drive_line(LINE_PX, $urandom_range(1, 5), -1, -1);
            end else begin
                drive_line($urandom_range(1, 45), $urandom_range(1, 5), -1, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
